mr_if: RTL and testbench

- Instruction fetch stage. Drives the inst/inst_pc/inst_valid/inst_ready stream consumed by decode.
- Issues sequential word fetches on a simple request/response instruction-memory port.
- Buffers returned words in a small FIFO.
- Accepts a PC redirect from the branch/writeback path, flushing the FIFO and dropping wrong-path responses still in flight.

---
 rtl/mr_if_pkg.sv | 13 +
 rtl/mr_if_if.sv | 32 +++
 rtl/mr_if_fifo.sv | 55 +++++
 rtl/mr_if.sv | 115 +++++++++++
 tb/tb_mr_if.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/mr_if_pkg.sv
// rtl/mr_if_pkg.sv - shared state encoding and PC step for the fetch stage
package mr_if_pkg;

  typedef enum logic [1:0] {
    IF_STATE_BOOT  = 2'd0,
    IF_STATE_RUN   = 2'd1,
    IF_STATE_DRAIN = 2'd2
  } if_state_e;

  localparam int IALIGN = 32;
  localparam int PC_INC = IALIGN / 8;

endpackage

// File: rtl/mr_if_if.sv
// rtl/mr_if_if.sv - fetch stage bundle: imem port, decode stream, redirect
interface mr_if_if #(
  parameter int XLEN    = 32,
  parameter int IMAXLEN = 32
);

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [XLEN-1:0]    imem_req_addr;
  logic               imem_resp_valid;
  logic [IMAXLEN-1:0] imem_resp_data;
  logic [IMAXLEN-1:0] inst;
  logic [XLEN-1:0]    inst_pc;
  logic               inst_valid;
  logic               inst_ready;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               fetch_misaligned;

  modport master (
    output imem_req_valid, imem_req_addr, inst, inst_pc, inst_valid, fetch_misaligned,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst, inst_pc, inst_valid, fetch_misaligned,
    output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/mr_if_fifo.sv
// rtl/mr_if_fifo.sv - synchronous FIFO with flush and a zero-latency head
module mr_if_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mr_if.sv
// rtl/mr_if.sv - instruction fetch stage with credit-limited requests and redirect flush
module mr_if
  import mr_if_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              IMAXLEN    = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input logic    clk,
  input logic    rst,
  mr_if_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if_state_e          state;
  logic [XLEN-1:0]    fetch_pc;
  logic [XLEN-1:0]    resp_pc;
  logic [CW-1:0]      outstanding;
  logic [CW-1:0]      drop_cnt;
  logic               misaligned_q;

  logic [CW-1:0]      fifo_count;
  logic               fifo_empty;
  logic               fifo_full;
  logic [IMAXLEN+XLEN-1:0] fifo_head;

  logic [CW:0]        credit_used;
  logic               req_hs;
  logic               push;
  logic               pop;
  logic               drop_now;
  logic [CW-1:0]      outstanding_next;
  logic [CW-1:0]      drop_cnt_next;
  logic [XLEN-1:0]    redirect_base;

  // Every in-flight request plus every buffered word holds one FIFO slot.
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};

  assign bus.imem_req_valid = (state == IF_STATE_RUN) && !bus.redirect_valid &&
                              (credit_used < (CW+1)'(FIFO_DEPTH));
  assign bus.imem_req_addr  = fetch_pc;
  assign req_hs             = bus.imem_req_valid && bus.imem_req_ready;

  assign drop_now      = bus.imem_resp_valid && (drop_cnt != '0);
  assign push          = bus.imem_resp_valid && (drop_cnt == '0) && !bus.redirect_valid;
  assign drop_cnt_next = drop_now ? drop_cnt - 1'b1 : drop_cnt;

  assign bus.inst_valid = !fifo_empty && !bus.redirect_valid && (state != IF_STATE_BOOT);
  assign pop            = bus.inst_valid && bus.inst_ready;
  assign {bus.inst, bus.inst_pc} = fifo_head;
  assign bus.fetch_misaligned    = misaligned_q;

  assign outstanding_next = outstanding + CW'(req_hs) - CW'(bus.imem_resp_valid);
  assign redirect_base    = {bus.redirect_pc[XLEN-1:2], 2'b00};

  mr_if_fifo #(
    .WIDTH (IMAXLEN + XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.redirect_valid),
    .push  (push),
    .wdata ({bus.imem_resp_data, resp_pc}),
    .pop   (pop),
    .rdata (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IF_STATE_BOOT;
      fetch_pc     <= RESET_PC;
      resp_pc      <= RESET_PC;
      outstanding  <= '0;
      drop_cnt     <= '0;
      misaligned_q <= 1'b0;
    end else begin
      outstanding  <= outstanding_next;
      misaligned_q <= bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
      if (bus.redirect_valid) begin
        // Everything still in flight belongs to the old path.
        fetch_pc <= redirect_base;
        resp_pc  <= redirect_base;
        drop_cnt <= outstanding_next;
        state    <= (outstanding_next != '0) ? IF_STATE_DRAIN : IF_STATE_RUN;
      end else begin
        if (req_hs) begin
          fetch_pc <= fetch_pc + XLEN'(PC_INC);
        end
        if (push) begin
          resp_pc <= resp_pc + XLEN'(PC_INC);
        end
        drop_cnt <= drop_cnt_next;
        case (state)
          IF_STATE_BOOT:  state <= IF_STATE_RUN;
          IF_STATE_DRAIN: state <= (drop_cnt_next == '0) ? IF_STATE_RUN : IF_STATE_DRAIN;
          default:        state <= IF_STATE_RUN;
        endcase
      end
    end
  end

  a_outstanding_bound: assert property (@(posedge clk) disable iff (rst)
    outstanding <= CW'(FIFO_DEPTH));
  a_no_spurious_resp: assert property (@(posedge clk) disable iff (rst)
    !(bus.imem_resp_valid && (outstanding == '0)));
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(push && fifo_full));

endmodule

// File: tb/tb_mr_if.sv
// tb/tb_mr_if.sv - randomized bench for mr_if against a queue-based fetch model
module tb_mr_if;

  localparam int          XLEN     = 32;
  localparam int          IMAXLEN  = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed { logic [31:0] addr; logic drop; } flight_t;
  typedef struct packed { logic [31:0] pc; logic [31:0] data; } entry_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mr_if_if #(.XLEN(XLEN), .IMAXLEN(IMAXLEN)) bus ();

  mr_if #(
    .XLEN       (XLEN),
    .IMAXLEN    (IMAXLEN),
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  flight_t     flight[$];
  entry_t      buffered[$];
  logic [31:0] next_addr;
  bit          boot;
  bit          mis_exp;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          p_rdy, p_resp, p_irdy, p_redir;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  task automatic drive();
    logic [31:0] t;
    bus.imem_req_ready = ($urandom_range(99) < p_rdy);
    if (flight.size() > 0 && $urandom_range(99) < p_resp) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_word(flight[0].addr);
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = $urandom;
    end
    bus.inst_ready     = ($urandom_range(99) < p_irdy);
    bus.redirect_valid = ($urandom_range(99) < p_redir);
    t = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15))
                                 : 32'($urandom_range(1023));
    bus.redirect_pc = t;
  endtask

  // One cycle: compare against the model, then advance it with what happened.
  task automatic step();
    bit      run_ok, exp_rv, exp_iv, req_hs, inst_hs, redir;
    flight_t f;
    @(negedge clk);
    redir  = bus.redirect_valid;
    run_ok = !boot;
    foreach (flight[i]) if (flight[i].drop) run_ok = 0;
    exp_rv = run_ok && (flight.size() + buffered.size() < DEPTH) && !redir;
    check("req_valid", bus.imem_req_valid, exp_rv);
    if (exp_rv) check("req_addr", bus.imem_req_addr, next_addr);
    exp_iv = (buffered.size() > 0) && !redir && !boot;
    check("inst_valid", bus.inst_valid, exp_iv);
    if (exp_iv) begin
      check("inst_pc", bus.inst_pc, buffered[0].pc);
      check("inst", bus.inst, buffered[0].data);
    end
    check("misaligned", bus.fetch_misaligned, mis_exp);

    req_hs  = bus.imem_req_valid && bus.imem_req_ready;
    inst_hs = exp_iv && bus.inst_ready;
    if (inst_hs) void'(buffered.pop_front());
    if (bus.imem_resp_valid && flight.size() > 0) begin
      f = flight.pop_front();
      if (!f.drop && !redir) buffered.push_back('{pc: f.addr, data: mem_word(f.addr)});
    end
    if (req_hs) flight.push_back('{addr: bus.imem_req_addr, drop: redir});
    mis_exp = redir && (bus.redirect_pc[1:0] != 2'b00);
    if (redir) begin
      buffered.delete();
      foreach (flight[i]) flight[i].drop = 1'b1;
      next_addr = {bus.redirect_pc[31:2], 2'b00};
    end else if (req_hs) begin
      next_addr = next_addr + 32'd4;
    end
    boot = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive();
      step();
    end
  endtask

  task automatic run_redirect(input logic [31:0] pc);
    drive();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    step();
  endtask

  task automatic do_reset();
    rst                 = 1'b1;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.inst_ready      = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_req_valid", bus.imem_req_valid, 0);
    check("rst_inst_valid", bus.inst_valid, 0);
    check("rst_misaligned", bus.fetch_misaligned, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    flight.delete();
    buffered.delete();
    next_addr = RESET_PC;
    boot      = 1;
    mis_exp   = 0;
  endtask

  initial begin
    bit hit;
    do_reset();

    // Streaming with an always-ready memory and decode.
    p_rdy = 100; p_resp = 100; p_irdy = 100; p_redir = 0;
    run(20);

    // Decode stall fills the buffer, then drains in order.
    p_irdy = 0;
    run(10);
    p_irdy = 100;
    run(10);

    // Two requests in flight, then redirect to 0x100.
    p_resp = 0; p_irdy = 0;
    run(3);
    p_resp = 100; p_irdy = 100;
    run_redirect(32'h0000_0100);
    run(10);

    // Redirect colliding with a response and a decode handshake attempt.
    run_redirect(32'h0000_0180);
    run(6);

    // Misaligned target.
    run_redirect(32'h0000_0202);
    run(8);

    // Wrap at the top of the address space.
    run_redirect(32'hFFFF_FFF8);
    run(10);

    // Randomized traffic.
    p_rdy = 70; p_resp = 50; p_irdy = 60; p_redir = 5;
    run(3000);

    // Reset while draining with exactly one dropped response in flight.
    p_rdy = 90; p_resp = 30; p_irdy = 50; p_redir = 25;
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      if (flight.size() == 1 && flight[0].drop) hit = 1;
      else run(1);
    end
    check("drain_reached", hit, 1);
    do_reset();
    p_rdy = 100; p_resp = 100; p_irdy = 100; p_redir = 0;
    run(20);

    p_rdy = 60; p_resp = 60; p_irdy = 70; p_redir = 8;
    run(2000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
